// File: rtl/stage2_pkg.sv
// Shared constants for the pipelined stage 2 range update / normalization.
// Consumed by stage_2_pipe; the STAGE2_BOOL_EN build option lives in the top.
package stage2_pkg;

   localparam int unsigned RANGE_WIDTH_DEF  = 16;
   localparam int unsigned D_SIZE_DEF       = 5;
   localparam int unsigned SYMBOL_WIDTH_DEF = 4;
   localparam int unsigned RR_SHIFT_DEF     = 8;
   localparam int unsigned BOOL_OFFSET_DEF  = 4;

   // bool_symbol = {bool_flag, symbol[0]}
   localparam int unsigned BOOL_SYM_W    = 2;
   localparam int unsigned BOOL_SYM_FLAG = 1;
   localparam int unsigned BOOL_SYM_BIT  = 0;

   typedef logic [BOOL_SYM_W-1:0] bool_sym_t;

   function automatic bool_sym_t pack_bool_symbol(input logic flag, input logic sym);
      bool_sym_t r;
      r                = '0;
      r[BOOL_SYM_FLAG] = flag;
      r[BOOL_SYM_BIT]  = sym;
      return r;
   endfunction

endpackage

// File: rtl/leading_zero.sv
// Leading-zero counter; d is the count from the MSB, v flags a nonzero input.
// An all-zero input reports d = 0, v = 0.
module leading_zero #(
   parameter int unsigned RANGE_WIDTH_LCZ = 16,
   parameter int unsigned D_SIZE_LZC      = 5
) (
   input  logic [RANGE_WIDTH_LCZ-1:0] value,
   output logic [D_SIZE_LZC-1:0]      d,
   output logic                       v
);

   // Priority scan from the MSB; the first set bit wins.
   always_comb begin
      d = '0;
      v = 1'b0;
      for (int i = RANGE_WIDTH_LCZ - 1; i >= 0; i--) begin
         if (!v && value[i]) begin
            d = D_SIZE_LZC'(RANGE_WIDTH_LCZ - 1 - i);
            v = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stage_2_pipe.sv
// Two-stage, back-pressured Q15/boolean range update with one-round normalization.
// Build option: define STAGE2_BOOL_EN to implement the boolean (v_bool) path.
module stage_2_pipe
   import stage2_pkg::*;
#(
   parameter int unsigned RANGE_WIDTH  = RANGE_WIDTH_DEF,
   parameter int unsigned D_SIZE       = D_SIZE_DEF,
   parameter int unsigned SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
   parameter int unsigned RR_SHIFT     = RR_SHIFT_DEF,
   parameter int unsigned BOOL_OFFSET  = BOOL_OFFSET_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [RANGE_WIDTH-1:0]  UU,
   input  logic [RANGE_WIDTH-1:0]  VV,
   input  logic [RANGE_WIDTH-1:0]  in_range,
   input  logic [RANGE_WIDTH-1:0]  lut_u,
   input  logic [RANGE_WIDTH-1:0]  lut_v,
   input  logic                    COMP_mux_1,
   input  logic [SYMBOL_WIDTH-1:0] symbol,
   input  logic                    bool_flag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RANGE_WIDTH:0]    u,
   output logic [RANGE_WIDTH:0]    v_bool,
   output logic [RANGE_WIDTH-1:0]  initial_range,
   output logic [RANGE_WIDTH-1:0]  out_range,
   output logic [D_SIZE-1:0]       out_d,
   output logic [BOOL_SYM_W-1:0]   bool_symbol,
   output logic                    COMP_mux_1_out,
   output logic                    range_zero
);

   localparam int unsigned RW = RANGE_WIDTH;
   localparam int unsigned UW = RANGE_WIDTH + 1;
   localparam int unsigned PW = 2 * RANGE_WIDTH;

   typedef struct packed {
      logic [UW-1:0] u;
      logic [RW-1:0] v;
      logic [UW-1:0] v_bool;
      logic [RW-1:0] in_range;
      logic          comp;
      logic          bool_flag;
      logic          sym;
   } s1_t;

   logic [RW-1:0] rr_c;
   logic [PW-1:0] prod_u_c;
   logic [PW-1:0] prod_v_c;
   logic [UW-1:0] u_c;
   logic [RW-1:0] v_c;
   logic [UW-1:0] v_bool_c;
   logic          bool_c;
   logic          unused_in;

   // S1 arithmetic at double width, truncated afterwards
   assign rr_c     = in_range >> RR_SHIFT;
   assign prod_u_c = PW'(rr_c) * PW'(UU);
   assign prod_v_c = PW'(rr_c) * PW'(VV);
   assign u_c      = UW'((prod_u_c >> 1) + PW'(lut_u));
   assign v_c      = RW'((prod_v_c >> 1) + PW'(lut_v));

`ifdef STAGE2_BOOL_EN
   assign bool_c   = bool_flag;
   assign v_bool_c = UW'((prod_v_c >> 1) + PW'(BOOL_OFFSET));
`else
   assign bool_c   = 1'b0;
   assign v_bool_c = '0;
`endif

   // Only symbol[0] matters; bool_flag is ignored when the boolean path is absent.
   assign unused_in = ^{bool_flag, symbol[SYMBOL_WIDTH-1:1]};

   logic s1_valid;
   logic s2_valid;
   logic s2_load_c;
   s1_t  s1_q;

   // Stall chain: S2 loads when empty or draining; S1 may accept whenever S2 loads.
   assign s2_load_c = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_load_c;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= '{u:         u_c,
                      v:         v_c,
                      v_bool:    v_bool_c,
                      in_range:  in_range,
                      comp:      COMP_mux_1,
                      bool_flag: bool_c,
                      sym:       symbol[0]};
         end
      end
   end

   logic [RW-1:0]     sel_c;
   logic [D_SIZE-1:0] lzc_d;
   logic              lzc_v;

   // S2 range select; subtractions wrap in RW bits
   always_comb begin
      sel_c = '0;
      if (s1_q.bool_flag) begin
         sel_c = s1_q.sym ? s1_q.v_bool[RW-1:0] : s1_q.in_range - s1_q.v_bool[RW-1:0];
      end else if (s1_q.comp) begin
         sel_c = s1_q.u[RW-1:0] - s1_q.v;
      end else begin
         sel_c = s1_q.in_range - s1_q.v;
      end
   end

   leading_zero #(
      .RANGE_WIDTH_LCZ (RW),
      .D_SIZE_LZC      (D_SIZE)
   ) u_lzc (
      .value (sel_c),
      .d     (lzc_d),
      .v     (lzc_v)
   );

   // A zero range still passes through, flagged, with no shift applied.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid       <= 1'b0;
         u              <= '0;
         v_bool         <= '0;
         initial_range  <= '0;
         out_range      <= '0;
         out_d          <= '0;
         bool_symbol    <= '0;
         COMP_mux_1_out <= 1'b0;
         range_zero     <= 1'b0;
      end else if (s2_load_c) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            u              <= s1_q.u;
            v_bool         <= s1_q.v_bool;
            initial_range  <= s1_q.in_range;
            out_range      <= lzc_v ? RW'(sel_c << lzc_d) : '0;
            out_d          <= lzc_v ? lzc_d : '0;
            bool_symbol    <= pack_bool_symbol(s1_q.bool_flag, s1_q.sym);
            COMP_mux_1_out <= s1_q.comp;
            range_zero     <= !lzc_v;
         end
      end
   end

endmodule

// File: tb/tb_stage_2_pipe.sv
// Bench for stage_2_pipe: directed spec vectors, back-pressure, mid-stream reset,
// and a randomized stream against an arithmetic reference model with a beat queue.
module tb_stage_2_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] UU, VV, in_range, lut_u, lut_v;
   logic        COMP_mux_1;
   logic [3:0]  symbol;
   logic        bool_flag;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] u, v_bool;
   logic [15:0] initial_range, out_range;
   logic [4:0]  out_d;
   logic [1:0]  bool_symbol;
   logic        COMP_mux_1_out;
   logic        range_zero;

   always #5 clk = ~clk;

   stage_2_pipe dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .UU(UU), .VV(VV), .in_range(in_range), .lut_u(lut_u), .lut_v(lut_v),
      .COMP_mux_1(COMP_mux_1), .symbol(symbol), .bool_flag(bool_flag),
      .out_valid(out_valid), .out_ready(out_ready), .u(u), .v_bool(v_bool),
      .initial_range(initial_range), .out_range(out_range), .out_d(out_d),
      .bool_symbol(bool_symbol), .COMP_mux_1_out(COMP_mux_1_out), .range_zero(range_zero)
   );

   typedef struct packed {
      logic [16:0] u;
      logic [16:0] vb;
      logic [15:0] init;
      logic [15:0] orange;
      logic [4:0]  d;
      logic [1:0]  bsym;
      logic        comp;
      logic        zero;
   } exp_t;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   exp_t        q[$];

   // Reference: plain integer arithmetic; normalize by doubling until the MSB is set.
   function automatic exp_t model(input logic [15:0] rng, input logic [15:0] uu,
                                  input logic [15:0] vv, input logic [15:0] lu,
                                  input logic [15:0] lv, input logic comp,
                                  input logic [3:0] sym, input logic bf);
      exp_t   e;
      longint rr, pu, pv, uval, vval, vb, r;
      int     d;
      logic   be;
`ifdef STAGE2_BOOL_EN
      be = 1'b1;
`else
      be = 1'b0;
`endif
      rr   = longint'(rng) / 256;
      pu   = rr * longint'(uu);
      pv   = rr * longint'(vv);
      uval = (pu / 2 + longint'(lu)) % 131072;
      vval = (pv / 2 + longint'(lv)) % 131072;
      vb   = be ? (pv / 2 + 4) % 131072 : 0;
      if (be && bf)
         r = sym[0] ? vb % 65536 : (longint'(rng) - vb % 65536 + 65536) % 65536;
      else if (comp)
         r = (uval - vval + 262144) % 65536;
      else
         r = (longint'(rng) - vval + 131072) % 65536;
      e.zero = (r == 0);
      d = 0;
      if (r != 0) begin
         while (r < 32768) begin
            r = r * 2;
            d++;
         end
      end
      e.u      = 17'(uval);
      e.vb     = 17'(vb);
      e.init   = rng;
      e.orange = 16'(r);
      e.d      = 5'(d);
      e.bsym   = {be & bf, sym[0]};
      e.comp   = comp;
      return e;
   endfunction

   function automatic exp_t observe();
      return {u, v_bool, initial_range, out_range, out_d, bool_symbol, COMP_mux_1_out, range_zero};
   endfunction

   function automatic exp_t model_now();
      return model(in_range, UU, VV, lut_u, lut_v, COMP_mux_1, symbol, bool_flag);
   endfunction

   task automatic drive_random(input logic valid);
      in_valid   = valid;
      in_range   = 16'($urandom);
      UU         = 16'($urandom);
      VV         = 16'($urandom);
      lut_u      = 16'($urandom);
      lut_v      = 16'($urandom);
      COMP_mux_1 = 1'($urandom);
      symbol     = 4'($urandom);
      bool_flag  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
         VV = UU; lut_v = lut_u; COMP_mux_1 = 1'b1; bool_flag = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) in_range = 16'($urandom_range(0, 1023));
   endtask

   task automatic test_reset();
      reset = 1'b0; out_ready = 1'b0;
      drive_random(1'b1);
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      vectors++;
      if (observe() !== exp_t'(0)) begin
         miscompares++; $display("FAIL reset_outputs: got %h want 0", observe());
      end
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   typedef struct packed {
      logic [15:0] uu, vv, lu, lv;
      logic        comp, sym, bf;
      logic [15:0] orange;
      logic [4:0]  d;
      logic [1:0]  bsym;
      logic        zero;
      logic [16:0] u, vb;
   } vec_t;

   // Hand-computed spec vectors: Q15 u-v, Q15 range-v, boolean sym=1/0, zero range.
   task automatic test_directed();
      vec_t t[5];
`ifdef STAGE2_BOOL_EN
      t[0] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b1, 1'b0, 1'b0, 16'h8010, 5'd2, 2'b00, 1'b0, 17'h4008, 17'h2004};
      t[1] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b0, 1'b0, 1'b0, 16'hBFF8, 5'd1, 2'b00, 1'b0, 17'h4008, 17'h2004};
      t[2] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b0, 1'b1, 1'b1, 16'h8010, 5'd2, 2'b11, 1'b0, 17'h4008, 17'h2004};
      t[3] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b1, 1'b0, 1'b1, 16'hBFF8, 5'd1, 2'b10, 1'b0, 17'h4008, 17'h2004};
      t[4] = '{16'h100, 16'h100, 16'd4, 16'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 2'b00, 1'b1, 17'h4004, 17'h4004};
`else
      t[0] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b1, 1'b0, 1'b0, 16'h8010, 5'd2, 2'b00, 1'b0, 17'h4008, 17'h0};
      t[1] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b0, 1'b0, 1'b0, 16'hBFF8, 5'd1, 2'b00, 1'b0, 17'h4008, 17'h0};
      t[2] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b0, 1'b1, 1'b1, 16'hBFF8, 5'd1, 2'b01, 1'b0, 17'h4008, 17'h0};
      t[3] = '{16'h100, 16'h080, 16'd8, 16'd4, 1'b1, 1'b0, 1'b1, 16'h8010, 5'd2, 2'b00, 1'b0, 17'h4008, 17'h0};
      t[4] = '{16'h100, 16'h100, 16'd4, 16'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 2'b00, 1'b1, 17'h4004, 17'h0};
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b1; in_range = 16'h8000;
         UU = t[i].uu; VV = t[i].vv; lut_u = t[i].lu; lut_v = t[i].lv;
         COMP_mux_1 = t[i].comp; symbol = {3'b101, t[i].sym}; bool_flag = t[i].bf;
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL dir%0d_latency1: out_valid %b want 0", i, out_valid);
         end
         @(negedge clk);
         #1;
         vectors++;
         if (out_valid !== 1'b1) begin
            miscompares++; $display("FAIL dir%0d_latency2: out_valid %b want 1", i, out_valid);
         end
         vectors++;
         if ({out_range, out_d, bool_symbol, range_zero} !== {t[i].orange, t[i].d, t[i].bsym, t[i].zero}) begin
            miscompares++;
            $display("FAIL dir%0d_result: range %h d %0d bsym %b zero %b want %h %0d %b %b",
                     i, out_range, out_d, bool_symbol, range_zero, t[i].orange, t[i].d, t[i].bsym, t[i].zero);
         end
         vectors++;
         if ({u, v_bool, initial_range, COMP_mux_1_out} !== {t[i].u, t[i].vb, 16'h8000, t[i].comp}) begin
            miscompares++;
            $display("FAIL dir%0d_fwd: u %h v_bool %h init %h comp %b want %h %h 8000 %b",
                     i, u, v_bool, initial_range, COMP_mux_1_out, t[i].u, t[i].vb, t[i].comp);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      int   sent = 0, got = 0;
      logic need_new = 1'b1;
      exp_t held = '0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 5);
         if (sent < 4 && need_new) begin
            drive_random(1'b1);
            need_new = 1'b0;
         end else if (sent >= 4) begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               miscompares++;
               $display("FAIL bp_full_c%0d: in_ready %b out_valid %b want 0 1", cyc, in_ready, out_valid);
            end
            if (cyc == 2) held = observe();
            else begin
               vectors++;
               if (observe() !== held) begin
                  miscompares++; $display("FAIL bp_hold_c%0d: got %h want %h", cyc, observe(), held);
               end
            end
         end
         if (out_valid) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL bp_extra_beat: got %h want none", observe());
            end else if (observe() !== q[0]) begin
               miscompares++; $display("FAIL bp_beat%0d: got %h want %h", got, observe(), q[0]);
            end
            if (out_ready && q.size() != 0) begin
               void'(q.pop_front());
               got++;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model_now());
            sent++;
            need_new = 1'b1;
         end
      end
      vectors++;
      if (got != 4 || q.size() != 0) begin
         miscompares++; $display("FAIL bp_count: got %0d beats (%0d left) want 4 (0)", got, q.size());
      end
      q.delete();
      in_valid = 1'b0;
   endtask

   task automatic test_random_stream();
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (cyc < 580) begin
            if (!in_valid || in_ready) drive_random($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         #1;
         vectors++;
         if (in_ready !== !(q.size() == 2 && !out_ready)) begin
            miscompares++;
            $display("FAIL rnd_in_ready c%0d: got %b want %b (occupancy %0d)", cyc, in_ready,
                     !(q.size() == 2 && !out_ready), q.size());
         end
         if (out_valid) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL rnd_extra_beat c%0d: got %h want none", cyc, observe());
            end else if (observe() !== q[0]) begin
               miscompares++; $display("FAIL rnd_beat c%0d: got %h want %h", cyc, observe(), q[0]);
            end
            if (out_ready && q.size() != 0) void'(q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(model_now());
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++; $display("FAIL rnd_drain: %0d beats left want 0", q.size());
      end
      q.delete();
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive_random(1'b1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || observe() !== exp_t'(0)) begin
         miscompares++; $display("FAIL rst_mid: out_valid %b data %h want 0 0", out_valid, observe());
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      drive_random(1'b1);
      #1;
      e = model_now();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid_lat1: out_valid %b want 0", out_valid);
      end
      @(negedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || observe() !== e) begin
         miscompares++; $display("FAIL rst_mid_lat2: valid %b data %h want 1 %h", out_valid, observe(), e);
      end
      @(negedge clk);
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0;
      in_range = '0; UU = '0; VV = '0; lut_u = '0; lut_v = '0;
      COMP_mux_1 = 1'b0; symbol = '0; bool_flag = 1'b0;
      test_reset();
      test_directed();
      test_back_pressure();
      test_random_stream();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
